// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencer sitting in front of the CSR register file.
// Classifies each committed instruction (normal / ecall / illegal / mret),
// emits the trap-side CSR write strobes and redirects fetch to mtvec or mepc.
// Optional feature: define TRAP_CTRL_TIMER_IRQ_EN to add a level-sensitive
// machine timer interrupt input (timer_irq_i), taken in IDLE when MIE is set.
module trap_ctrl #(
  parameter int XLEN          = 64,
  parameter int CAUSE_ILLEGAL = 2,
  parameter int CAUSE_ECALL_M = 11
) (
  input  logic            clk,
  input  logic            rst,
`ifdef TRAP_CTRL_TIMER_IRQ_EN
  input  logic            timer_irq_i,
`endif
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic            is_ecall_i,
  input  logic            is_mret_i,
  input  logic            is_illegal_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mstatus_i,
  output logic            panic_o,
  output logic            pc_mret_o,
  output logic            wmepc_o,
  output logic [XLEN-1:0] mepc_v_o,
  output logic            wmcause_o,
  output logic [XLEN-1:0] mcause_v_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  // Interrupt flag in the MSB, exception code 7 (machine timer) in the LSBs.
  localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, {(XLEN-4){1'b0}}, 3'd7};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAVE = 2'd1,
    JUMP = 2'd2,
    MRET = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] epc_q,   epc_d;
  logic [XLEN-1:0] cause_q, cause_d;

  logic accept;
  logic take_irq;
  logic unused_inputs;

  // A new instruction is only consumed while no sequence is in flight.
  assign accept = valid_i & (state_q == IDLE);

`ifdef TRAP_CTRL_TIMER_IRQ_EN
  // The pending interrupt steals the accepted slot; the instruction itself
  // is not executed and will be re-fetched after the handler returns.
  assign take_irq      = accept & timer_irq_i & mstatus_i[3];
  assign unused_inputs = ^{mstatus_i[XLEN-1:4], mstatus_i[2:0], mtvec_i[1:0]};
`else
  assign take_irq      = 1'b0;
  assign unused_inputs = ^{mstatus_i, mtvec_i[1:0]};
`endif

  // State and captured trap context; reset aborts any sequence immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and capture: classify on accept with illegal > ecall > mret.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    unique case (state_q)
      IDLE: begin
        if (take_irq) begin
          // Interrupts record the exact PC of the instruction not executed.
          state_d = SAVE;
          epc_d   = pc_i;
          cause_d = IRQ_CAUSE;
        end else if (accept && is_illegal_i) begin
          state_d = SAVE;
          epc_d   = {pc_i[XLEN-1:2], 2'b00};
          cause_d = XLEN'(CAUSE_ILLEGAL);
        end else if (accept && is_ecall_i) begin
          state_d = SAVE;
          epc_d   = {pc_i[XLEN-1:2], 2'b00};
          cause_d = XLEN'(CAUSE_ECALL_M);
        end else if (accept && is_mret_i) begin
          state_d = MRET;
        end
      end
      SAVE:    state_d = JUMP;
      JUMP:    state_d = IDLE;
      MRET:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode: everything depends on state and captured context,
  // plus the CSR values that are deliberately read late (mtvec, mepc).
  always_comb begin
    ready_o       = 1'b0;
    panic_o       = 1'b0;
    pc_mret_o     = 1'b0;
    wmepc_o       = 1'b0;
    mepc_v_o      = '0;
    wmcause_o     = 1'b0;
    mcause_v_o    = '0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
      end
      SAVE: begin
        panic_o    = 1'b1;
        wmepc_o    = 1'b1;
        mepc_v_o   = epc_q;
        wmcause_o  = 1'b1;
        mcause_v_o = cause_q;
      end
      JUMP: begin
        // mtvec is read here, one cycle after SAVE, so a freshly written
        // value is honoured. Only direct mode: the mode bits are dropped.
        redirect_o    = 1'b1;
        redirect_pc_o = {mtvec_i[XLEN-1:2], 2'b00};
      end
      MRET: begin
        pc_mret_o     = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = mepc_i;
      end
      default: begin
        ready_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed plus randomized stimulus for trap_ctrl with a
// scoreboard. The driver predicts each cycle's outputs from the architectural
// rules and queues them; the monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_trap_ctrl;

  localparam int XLEN = 64;
  localparam logic [XLEN-1:0] IRQ_CAUSE = 64'h8000_0000_0000_0007;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            timer_irq_i = 1'b0;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [XLEN-1:0] pc_i = '0;
  logic            is_ecall_i = 1'b0;
  logic            is_mret_i = 1'b0;
  logic            is_illegal_i = 1'b0;
  logic [XLEN-1:0] mtvec_i = '0;
  logic [XLEN-1:0] mepc_i = '0;
  logic [XLEN-1:0] mstatus_i = '0;
  logic            panic_o, pc_mret_o, wmepc_o, wmcause_o, redirect_o;
  logic [XLEN-1:0] mepc_v_o, mcause_v_o, redirect_pc_o;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(XLEN), .CAUSE_ILLEGAL(2), .CAUSE_ECALL_M(11)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef TRAP_CTRL_TIMER_IRQ_EN
    .timer_irq_i  (timer_irq_i),
`endif
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .pc_i         (pc_i),
    .is_ecall_i   (is_ecall_i),
    .is_mret_i    (is_mret_i),
    .is_illegal_i (is_illegal_i),
    .mtvec_i      (mtvec_i),
    .mepc_i       (mepc_i),
    .mstatus_i    (mstatus_i),
    .panic_o      (panic_o),
    .pc_mret_o    (pc_mret_o),
    .wmepc_o      (wmepc_o),
    .mepc_v_o     (mepc_v_o),
    .wmcause_o    (wmcause_o),
    .mcause_v_o   (mcause_v_o),
    .redirect_o   (redirect_o),
    .redirect_pc_o(redirect_pc_o)
  );

  // One expected output cycle of a trap/mret sequence.
  typedef struct {
    logic            panic, pc_mret, wmepc, wmcause, redirect;
    logic [XLEN-1:0] mepc_v, mcause_v, redirect_pc;
  } exp_t;

  // Pending architectural action: 1 = save context, 2 = jump to mtvec, 3 = mret.
  typedef struct {
    int              act;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] cause;
  } plan_t;

  exp_t  sb[$];
  plan_t plan[$];
  bit    exp_ready = 1'b1;
  int    checks = 0;
  int    failures = 0;
  int    txns = 0;

  // One cycle of stimulus: predicts this cycle's outputs, then applies inputs.
  task automatic drive_cycle(input bit v, input bit il, input bit ec, input bit mr,
                             input bit irq, input logic [XLEN-1:0] pc,
                             input logic [XLEN-1:0] mtvec, input logic [XLEN-1:0] mepc,
                             input logic [XLEN-1:0] mstatus);
    plan_t p;
    exp_t  e;
    bit    irq_taken;
    @(posedge clk);
    #1;
    valid_i      = v;
    is_illegal_i = il;
    is_ecall_i   = ec;
    is_mret_i    = mr;
    timer_irq_i  = irq;
    pc_i         = pc;
    mtvec_i      = mtvec;
    mepc_i       = mepc;
    mstatus_i    = mstatus;
    p = '{0, '0, '0};
    if (plan.size() > 0) p = plan.pop_front();
    e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0};
    if (p.act == 1) begin
      e.panic = 1'b1; e.wmepc = 1'b1; e.wmcause = 1'b1;
      e.mepc_v = p.epc; e.mcause_v = p.cause;
    end else if (p.act == 2) begin
      e.redirect = 1'b1; e.redirect_pc = mtvec & ~64'h3;
    end else if (p.act == 3) begin
      e.pc_mret = 1'b1; e.redirect = 1'b1; e.redirect_pc = mepc;
    end
    if (p.act != 0) sb.push_back(e);
    exp_ready = (p.act == 0);
    if (v && exp_ready) begin
      irq_taken = 1'b0;
`ifdef TRAP_CTRL_TIMER_IRQ_EN
      irq_taken = irq && mstatus[3];
`endif
      if (irq_taken) begin
        plan.push_back('{1, pc, IRQ_CAUSE});
        plan.push_back('{2, '0, '0});
      end else if (il) begin
        plan.push_back('{1, pc & ~64'h3, 64'd2});
        plan.push_back('{2, '0, '0});
      end else if (ec) begin
        plan.push_back('{1, pc & ~64'h3, 64'd11});
        plan.push_back('{2, '0, '0});
      end else if (mr) begin
        plan.push_back('{3, '0, '0});
      end
    end
  endtask

  task automatic idle_cycle(input logic [XLEN-1:0] mtvec, input logic [XLEN-1:0] mepc);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, mtvec, mepc, '0);
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (ready_o !== 1'b1 || panic_o !== 1'b0 || pc_mret_o !== 1'b0 || wmepc_o !== 1'b0 ||
        wmcause_o !== 1'b0 || redirect_o !== 1'b0 || mepc_v_o !== '0 ||
        mcause_v_o !== '0 || redirect_pc_o !== '0) begin
      failures++;
      $display("FAIL %s: got ready=%0b panic=%0b mret=%0b wmepc=%0b wmcause=%0b redir=%0b mepc_v=%h mcause_v=%h rpc=%h, need ready=1 and all else 0",
               name, ready_o, panic_o, pc_mret_o, wmepc_o, wmcause_o, redirect_o,
               mepc_v_o, mcause_v_o, redirect_pc_o);
    end
  endtask

  // Monitor: checks handshake readiness every cycle and pops one expectation
  // whenever the DUT strobes or an expectation is due.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (ready_o !== exp_ready) begin
        failures++;
        $display("FAIL ready: got %0b need %0b at %0t", ready_o, exp_ready, $time);
      end
      checks++;
      if (!redirect_o && redirect_pc_o !== '0) begin
        failures++;
        $display("FAIL redirect_pc_idle: got %h need 0", redirect_pc_o);
      end
      if (panic_o || pc_mret_o || wmepc_o || wmcause_o || redirect_o || sb.size() > 0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_strobe: got panic=%0b mret=%0b wmepc=%0b wmcause=%0b redir=%0b need none",
                   panic_o, pc_mret_o, wmepc_o, wmcause_o, redirect_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (panic_o !== e.panic || pc_mret_o !== e.pc_mret || wmepc_o !== e.wmepc ||
              wmcause_o !== e.wmcause || redirect_o !== e.redirect ||
              (e.wmepc && mepc_v_o !== e.mepc_v) ||
              (e.wmcause && mcause_v_o !== e.mcause_v) ||
              (e.redirect && redirect_pc_o !== e.redirect_pc)) begin
            failures++;
            $display("FAIL strobe_seq: got p=%0b m=%0b we=%0b wc=%0b r=%0b epc=%h cause=%h rpc=%h need p=%0b m=%0b we=%0b wc=%0b r=%0b epc=%h cause=%h rpc=%h",
                     panic_o, pc_mret_o, wmepc_o, wmcause_o, redirect_o, mepc_v_o, mcause_v_o, redirect_pc_o,
                     e.panic, e.pc_mret, e.wmepc, e.wmcause, e.redirect, e.mepc_v, e.mcause_v, e.redirect_pc);
          end else begin
            txns++;
            $display("txn %0d: panic=%0b mret=%0b mepc_v=%h mcause_v=%h redirect=%0b pc=%h",
                     txns, panic_o, pc_mret_o, mepc_v_o, mcause_v_o, redirect_o, redirect_pc_o);
          end
        end
      end
    end
  end

  initial begin
    logic [XLEN-1:0] tv;
    // Power-on reset held with the clock running.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst = 1'b0;

    // ecall: mepc=0x8000_0010, cause 11, redirect to mtvec with mode bits dropped.
    tv = 64'h8000_0101;
    idle_cycle(tv, '0);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0010, tv, '0, '0);
    idle_cycle(tv, '0);
    idle_cycle(tv, '0);
    idle_cycle(tv, '0);

    // illegal + ecall together: illegal wins; valid held while busy is ignored.
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 64'h8000_0026, tv, '0, '0);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0030, tv, '0, '0);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0030, 64'h8000_0204, '0, '0);
    idle_cycle(tv, '0);
    idle_cycle(tv, '0);
    idle_cycle(tv, '0);

    // mret with ecall raised too: ecall outranks mret, so this is a trap.
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h8000_0040, tv, '0, '0);
    idle_cycle(tv, '0);
    idle_cycle(tv, '0);

    // plain mret to mepc=0x8000_0014.
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h8000_0050, tv, 64'h8000_0014, '0);
    idle_cycle(tv, 64'h8000_0014);
    idle_cycle(tv, 64'h8000_0014);

    // four back-to-back normal instructions, no strobes expected.
    for (int i = 0; i < 4; i++)
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h8000_0060 + 64'(4*i), tv, '0, '0);
    idle_cycle(tv, '0);

    // reset asserted in SAVE with no clock edge: strobes must drop at once.
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h8000_0070, tv, '0, '0);
    idle_cycle(tv, '0);
    checks++;
    if (panic_o !== 1'b1) begin
      failures++;
      $display("FAIL save_before_reset: got panic=%0b need 1", panic_o);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_in_save");
    sb.delete();
    plan.delete();
    exp_ready = 1'b1;
    #1;
    rst = 1'b0;
    idle_cycle(tv, '0);
    idle_cycle(tv, '0);
    idle_cycle(tv, '0);

`ifdef TRAP_CTRL_TIMER_IRQ_EN
    // timer interrupt masked by MIE=0: the normal instruction just retires.
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0080, tv, '0, 64'h0);
    idle_cycle(tv, '0);
    // MIE=1: interrupt taken, outranks the illegal flag, exact pc kept.
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0020, tv, '0, 64'h8);
    idle_cycle(tv, '0);
    idle_cycle(tv, '0);
    idle_cycle(tv, '0);
`endif

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      logic [XLEN-1:0] rpc, rtv, rep, rms;
      rpc = {32'h0, $urandom};
      rtv = {$urandom, $urandom};
      rep = {$urandom, $urandom};
      rms = {$urandom, $urandom};
      drive_cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0), rpc, rtv, rep, rms);
    end

    // drain and confirm nothing is left outstanding
    for (int i = 0; i < 4; i++) idle_cycle(tv, '0);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || plan.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d expected and %0d planned left, need 0", sb.size(), plan.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
